// File: rtl/y_vector_reader.sv
`default_nettype none
// ============================================================================
//  Module   : y_vector_reader
//  Purpose  : Reading end of the wide packed y result bus. On a capture
//             request the bus is snapshotted into a shadow register and
//             streamed out LSB-first as CHUNK_W-bit beats over a valid/ready
//             handshake. Every accepted beat is folded into a 32-bit MISR so
//             DUT and golden tops can be compared beat-by-beat or by
//             signature alone.
//  Ports    : clk        - rising-edge clock
//             rst        - asynchronous active-high reset
//             y_in       - y vector from the DUT top (IN_W bits)
//             cap_req    - capture request, only honoured in IDLE
//             busy       - high whenever the FSM is not IDLE
//             out_data   - current beat (CHUNK_W bits)
//             out_valid  - beat valid
//             out_ready  - sink accepts the beat
//             out_last   - current beat is the final beat
//             out_idx    - index of the current beat, 0..NCHUNK-1
//             sig        - MISR signature
//             sig_valid  - one-cycle pulse when sig is final
//  Revision : 1.0 - initial release
// ============================================================================
module y_vector_reader #(
  parameter int          IN_W    = 686,
  parameter int          CHUNK_W = 32,
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter logic [31:0] SEED    = 32'hFFFFFFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IN_W-1:0]    y_in,
  input  logic               cap_req,
  output logic               busy,
  output logic [CHUNK_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic [4:0]         out_idx,
  output logic [31:0]        sig,
  output logic               sig_valid
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int         NCHUNK   = (IN_W + CHUNK_W - 1) / CHUNK_W;
  localparam int         PAD_W    = NCHUNK * CHUNK_W;
  localparam logic [4:0] LAST_IDX = 5'(NCHUNK - 1);

  // The MISR is exactly 32 bits wide and the beat index is 5 bits, so the
  // beat width and the beat count are both bounded at elaboration.
  generate
    if (CHUNK_W != 32) begin : g_chunk_w_chk
      $error("y_vector_reader: CHUNK_W must be 32");
    end
    if (NCHUNK > 32) begin : g_nchunk_chk
      $error("y_vector_reader: NCHUNK exceeds the 5-bit beat index");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [PAD_W-1:0]   shadow_q,    shadow_d;
  logic [4:0]         idx_q,       idx_d;
  logic               valid_q,     valid_d;
  logic [31:0]        sig_q,       sig_d;
  logic               busy_q,      busy_d;
  logic               sig_valid_q, sig_valid_d;

  logic [CHUNK_W-1:0] beat_w;
  logic [31:0]        misr_next_w;
  logic               accept_w;

  // --------------------------------------------------------------------------
  // Beat selection. The shadow is zero-padded up to a whole number of beats
  // at capture time, so the final beat is naturally zero-extended.
  // --------------------------------------------------------------------------
  always_comb begin
    beat_w = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx_q == 5'(k)) begin
        beat_w = shadow_q[k*CHUNK_W +: CHUNK_W];
      end
    end
  end

  assign accept_w    = valid_q & out_ready;
  assign misr_next_w = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ beat_w;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    sig_d    = sig_q;

    case (state_q)
      S_IDLE: begin
        if (cap_req) begin
          shadow_d = PAD_W'(y_in);
          sig_d    = SEED;
          idx_d    = 5'd0;
          valid_d  = 1'b1;
          state_d  = S_STREAM;
        end
      end

      S_STREAM: begin
        // Without an accept every stream output simply holds.
        if (accept_w) begin
          sig_d = misr_next_w;
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            idx_d   = 5'd0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        idx_d   = 5'd0;
      end
    endcase

    // Status flags are registered alongside the state so they line up with it.
    busy_d      = (state_d != S_IDLE);
    sig_valid_d = (state_d == S_DONE);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      idx_q       <= 5'd0;
      valid_q     <= 1'b0;
      sig_q       <= 32'h0;
      busy_q      <= 1'b0;
      sig_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      sig_q       <= sig_d;
      busy_q      <= busy_d;
      sig_valid_q <= sig_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy      = busy_q;
  assign out_data  = beat_w;
  assign out_valid = valid_q;
  // Gated by valid so a single-beat configuration does not flag last at rest.
  assign out_last  = valid_q & (idx_q == LAST_IDX);
  assign out_idx   = idx_q;
  assign sig       = sig_q;
  assign sig_valid = sig_valid_q;

endmodule
`default_nettype wire
